// File: rtl/traffic_phase_timer.sv
// Timing and sensing front end for the one-hot traffic-light controller.
// It tracks the current light phase and produces the green and yellow
// countdowns. It also qualifies the raw vehicle sensor (synchronise,
// debounce, minimum red dwell) and flags non-one-hot light combinations.
module traffic_phase_timer #(
   parameter int TICK_DIV = 1,
   parameter int DEBOUNCE = 4,
   parameter int MIN_RED  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        red_light,
   input  logic        green_light,
   input  logic        yellow_light,
   input  logic        sensor_raw,
   input  logic [15:0] green_time,
   input  logic [15:0] yellow_time,
   output logic        sensor,
   output logic [15:0] green_downcnt,
   output logic [15:0] yellow_downcnt,
   output logic        fault
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      P_RED    = 2'd0,
      P_GREEN  = 2'd1,
      P_YELLOW = 2'd2,
      P_FAULT  = 2'd3
   } phase_e;

   phase_e          phase_q, phase_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [15:0]     green_q, green_d;
   logic [15:0]     yellow_q, yellow_d;
   logic [15:0]     dwell_q, dwell_d;
   logic [DW-1:0]   run_q, run_d;
   logic            sync1_q, sync2_q;
   logic            deb_q, deb_d;
   logic            sensor_q, sensor_d;
   logic            fault_q, fault_d;
   logic            entry;
   logic            tick;

   // Next-state logic for phase, prescaler, countdowns, dwell, debounce and outputs.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      phase_d  = P_FAULT;
      presc_d  = presc_q;
      green_d  = green_q;
      yellow_d = yellow_q;
      dwell_d  = dwell_q;
      run_d    = '0;
      deb_d    = deb_q;

      unique case ({red_light, green_light, yellow_light})
         3'b100:  phase_d = P_RED;
         3'b010:  phase_d = P_GREEN;
         3'b001:  phase_d = P_YELLOW;
         default: phase_d = P_FAULT;
      endcase

      entry = (phase_d != phase_q);
      tick  = (presc_q == PW'(TICK_DIV - 1));

      // The prescaler restarts on every phase entry so the first tick of a
      // phase lands exactly TICK_DIV edges after the entry edge.
      if (entry || tick) presc_d = '0;
      else               presc_d = presc_q + 1'b1;

      // Counts freeze in fault. Outside their own phase (and on a fresh entry)
      // they track the duration inputs. Inside it they count down and saturate.
      if (phase_d != P_FAULT) begin
         if (phase_d != P_GREEN || entry)    green_d = green_time;
         else if (tick && green_q != 16'd0)  green_d = green_q - 16'd1;

         if (phase_d != P_YELLOW || entry)   yellow_d = yellow_time;
         else if (tick && yellow_q != 16'd0) yellow_d = yellow_q - 16'd1;
      end

      if (entry) dwell_d = '0;
      else if (phase_q == P_RED && tick && dwell_q != 16'hFFFF)
         dwell_d = dwell_q + 16'd1;

      // Debounce: the run count only grows while the synchronised level
      // disagrees with the debounced one. Any agreement resets it.
      if (sync2_q != deb_q) begin
         if (run_q == DW'(DEBOUNCE - 1)) deb_d = sync2_q;
         else                            run_d = run_q + 1'b1;
      end

      // Gating on the next phase drops sensor on the very edge red is left.
      sensor_d = deb_q && (phase_d == P_RED) && (dwell_q >= 16'(MIN_RED));
      fault_d  = (phase_d == P_FAULT);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments only.
         phase_q  <= P_RED;
         presc_q  <= '0;
         green_q  <= '0;
         yellow_q <= '0;
         dwell_q  <= '0;
         run_q    <= '0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         deb_q    <= 1'b0;
         sensor_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         presc_q  <= presc_d;
         green_q  <= green_d;
         yellow_q <= yellow_d;
         dwell_q  <= dwell_d;
         run_q    <= run_d;
         sync1_q  <= sensor_raw;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         sensor_q <= sensor_d;
         fault_q  <= fault_d;
      end
   end

   assign sensor         = sensor_q;
   assign green_downcnt  = green_q;
   assign yellow_downcnt = yellow_q;
   assign fault          = fault_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer. It uses the default instance plus a
// TICK_DIV=3 instance on the same inputs. All expected values are hand-derived.
module tb_traffic_phase_timer;

   logic        clock = 1'b0;
   logic        reset;
   logic        red_light, green_light, yellow_light;
   logic        sensor_raw;
   logic [15:0] green_time, yellow_time;
   logic        sensor, fault, sensor3, fault3;
   logic [15:0] green_downcnt, yellow_downcnt, green3, yellow3;

   int checks   = 0;
   int failures = 0;

   traffic_phase_timer dut (
      .clock(clock), .reset(reset),
      .red_light(red_light), .green_light(green_light), .yellow_light(yellow_light),
      .sensor_raw(sensor_raw), .green_time(green_time), .yellow_time(yellow_time),
      .sensor(sensor), .green_downcnt(green_downcnt),
      .yellow_downcnt(yellow_downcnt), .fault(fault)
   );

   traffic_phase_timer #(.TICK_DIV(3)) dut3 (
      .clock(clock), .reset(reset),
      .red_light(red_light), .green_light(green_light), .yellow_light(yellow_light),
      .sensor_raw(sensor_raw), .green_time(green_time), .yellow_time(yellow_time),
      .sensor(sensor3), .green_downcnt(green3),
      .yellow_downcnt(yellow3), .fault(fault3)
   );

   always #5 clock = ~clock;

   // One rising edge, then settle; outputs read after this reflect that edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic lights(input logic r, input logic g, input logic y);
      red_light = r; green_light = g; yellow_light = y;
   endtask

   initial begin
      reset = 1'b1; lights(1, 0, 0); sensor_raw = 1'b0;
      green_time = 16'd5; yellow_time = 16'd3;

      // Reset state.
      step(2);
      check("rst_sensor", {15'd0, sensor}, 16'd0);
      check("rst_fault",  {15'd0, fault},  16'd0);
      check("rst_green",  green_downcnt,   16'd0);
      check("rst_yellow", yellow_downcnt,  16'd0);

      // First edge after release preloads both counts.
      reset = 1'b0;
      step();
      check("rel_green",  green_downcnt,   16'd5);
      check("rel_yellow", yellow_downcnt,  16'd3);
      check("rel_sensor", {15'd0, sensor}, 16'd0);
      check("rel_fault",  {15'd0, fault},  16'd0);
      step(5);

      // 3-cycle glitch never reaches the debounced level.
      sensor_raw = 1'b1;
      step(3);
      sensor_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("glitch_sensor", {15'd0, sensor}, 16'd0);
      end

      // Steady 0->1: sensor rises exactly on the 7th edge.
      sensor_raw = 1'b1;
      step(6);
      check("sens_edge6", {15'd0, sensor}, 16'd0);
      step();
      check("sens_edge7", {15'd0, sensor}, 16'd1);

      // Enter green: sensor drops on the entry edge, count runs 5..0 then holds.
      lights(0, 1, 0);
      step();
      check("g_entry_sensor", {15'd0, sensor}, 16'd0);
      check("g_cnt0", green_downcnt, 16'd5);
      for (int k = 1; k <= 5; k++) begin
         step();
         check("g_cnt", green_downcnt, 16'(5 - k));
      end
      step();
      check("g_hold0",   green_downcnt,  16'd0);
      check("g_yellow3", yellow_downcnt, 16'd3);

      // Back to red with sensor still high: dwell restarts, so sensor is blocked for two more edges.
      lights(1, 0, 0);
      step(3);
      check("dwell_block", {15'd0, sensor}, 16'd0);
      step();
      check("dwell_open",  {15'd0, sensor}, 16'd1);

      // Fault mid-green at count 4: counts freeze, then a fresh green entry reloads.
      lights(0, 1, 0);
      step(2);
      check("pre_fault_cnt", green_downcnt, 16'd4);
      lights(1, 1, 0);
      step();
      check("fault_set",    {15'd0, fault},  16'd1);
      check("fault_hold1",  green_downcnt,   16'd4);
      check("fault_sensor", {15'd0, sensor}, 16'd0);
      step();
      check("fault_hold2",  green_downcnt,   16'd4);
      lights(0, 1, 0);
      step();
      check("fault_clear",  {15'd0, fault},  16'd0);
      check("fault_reload", green_downcnt,   16'd5);
      step();
      check("fault_dec",    green_downcnt,   16'd4);

      // Reset mid-yellow with count 2.
      lights(0, 0, 1);
      step(2);
      check("y_cnt2", yellow_downcnt, 16'd2);
      reset = 1'b1;
      step();
      check("mrst_yellow", yellow_downcnt,  16'd0);
      check("mrst_green",  green_downcnt,   16'd0);
      check("mrst_sensor", {15'd0, sensor}, 16'd0);
      check("mrst_fault",  {15'd0, fault},  16'd0);
      reset = 1'b0; lights(1, 0, 0);
      step();
      check("mrst_rl_green",  green_downcnt,  16'd5);
      check("mrst_rl_yellow", yellow_downcnt, 16'd3);
      step();
      check("mrst_blocked", {15'd0, sensor}, 16'd0);

      // Yellow entry with yellow_time=2 on both prescaler settings.
      yellow_time = 16'd2;
      step(4);
      lights(0, 0, 1);
      step();
      check("t3_e0", yellow3,        16'd2);
      check("t1_e0", yellow_downcnt, 16'd2);
      step();
      check("t3_e1", yellow3,        16'd2);
      check("t1_e1", yellow_downcnt, 16'd1);
      step();
      check("t3_e2", yellow3,        16'd2);
      check("t1_e2", yellow_downcnt, 16'd0);
      step();
      check("t3_e3", yellow3, 16'd1);
      step(2);
      check("t3_e5", yellow3, 16'd1);
      step();
      check("t3_e6", yellow3, 16'd0);
      step(3);
      check("t3_e9",    yellow3, 16'd0);
      check("t3_green", green3,  16'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
